// File: rtl/scanreg_bank.sv
// scanreg_bank: WIDTH-bit scan register bank with parallel load, manual/auto serial scan and optional shadow output stage.
// Latency: Load -> Q one cycle; auto-scan takes WIDTH shift edges plus one update edge after ScanStart is sampled.
// Backpressure: none; while Busy is high Load/Test/Update/ScanStart are ignored, and a held ScanStart restarts on return to IDLE.
//
// Ports:
//   Clock, Reset      rising-edge clock, synchronous active-high reset
//   D, Load           parallel data and load strobe (capture and output both take D)
//   Test, SDI         manual shift enable and serial input (enters bit 0)
//   Update            copy capture register to Q when SHADOW=1
//   ScanStart         begin an autonomous WIDTH-bit scan
//   SDO               serial output, capture register MSB (combinational)
//   Q, nQ             registered output and its inverse
//   Busy, ScanDone    auto-scan in progress / one-cycle completion pulse
module scanreg_bank #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter int              SHADOW      = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] D,
  input  logic             Load,
  input  logic             Test,
  input  logic             SDI,
  input  logic             Update,
  input  logic             ScanStart,
  output logic             SDO,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] nQ,
  output logic             Busy,
  output logic             ScanDone
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic             scan_done;

  logic [WIDTH-1:0] c_shift;
  logic [WIDTH-1:0] c_nxt;
  logic [WIDTH-1:0] q_nxt;

  // A one-bit bank has no lower bits to keep; the shift is just SDI.
  if (WIDTH == 1) begin : g_shift_w1
    assign c_shift = SDI;
  end else begin : g_shift_wn
    assign c_shift = {c[WIDTH-2:0], SDI};
  end

  // Capture register next value, following the IDLE priority
  // ScanStart > Test > Update > Load. ScanStart and Update leave C alone.
  always_comb begin
    c_nxt = c;
    case (state)
      IDLE: begin
        if (!ScanStart) begin
          if (Test) begin
            c_nxt = c_shift;
          end else if (!Update && Load) begin
            c_nxt = D;
          end
        end
      end
      SHIFT:   c_nxt = c_shift;
      default: c_nxt = c;
    endcase
  end

  // Output register next value. Without a shadow stage Q simply tracks
  // the capture register, so it ripples while shifting.
  always_comb begin
    q_nxt = q;
    if (SHADOW == 0) begin
      q_nxt = c_nxt;
    end else begin
      case (state)
        IDLE: begin
          if (!ScanStart && !Test) begin
            if (Update) begin
              q_nxt = c;
            end else if (Load) begin
              q_nxt = D;
            end
          end
        end
        UPDATE:  q_nxt = c;
        default: q_nxt = q;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      c         <= RESET_VALUE;
      q         <= RESET_VALUE;
      cnt       <= '0;
      busy      <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      c         <= c_nxt;
      q         <= q_nxt;
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ScanStart) begin
            cnt   <= CNT_LAST;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // cnt==0 marks the WIDTH-th shift edge.
          if (cnt == '0) begin
            state <= UPDATE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        UPDATE: begin
          scan_done <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign SDO      = c[WIDTH-1];
  assign Q        = q;
  assign nQ       = ~q;
  assign Busy     = busy;
  assign ScanDone = scan_done;

endmodule

// File: tb/tb_scanreg_bank.sv
module tb_scanreg_bank;

  localparam logic [7:0] RV = 8'hA5;

  logic       Clock;
  logic       Reset;
  logic [7:0] D;
  logic       Load;
  logic       Test;
  logic       SDI;
  logic       Update;
  logic       ScanStart;

  logic       sdo1, busy1, done1;
  logic [7:0] q1, nq1;
  logic       sdo0, busy0, done0;
  logic [7:0] q0, nq0;

  int total;
  int passed;
  int fails;

  // Reference state: capture contents and shadowed output value.
  // The non-shadowed bank's Q always equals the capture contents.
  logic [7:0] mc;
  logic [7:0] mq1;

  scanreg_bank #(.WIDTH(8), .RESET_VALUE(RV), .SHADOW(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .D(D), .Load(Load), .Test(Test), .SDI(SDI),
    .Update(Update), .ScanStart(ScanStart), .SDO(sdo1), .Q(q1), .nQ(nq1),
    .Busy(busy1), .ScanDone(done1)
  );

  scanreg_bank #(.WIDTH(8), .RESET_VALUE(RV), .SHADOW(0)) dut0 (
    .Clock(Clock), .Reset(Reset), .D(D), .Load(Load), .Test(Test), .SDI(SDI),
    .Update(Update), .ScanStart(ScanStart), .SDO(sdo0), .Q(q0), .nQ(nq0),
    .Busy(busy0), .ScanDone(done0)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    logic [7:0] inv1, inv0;
    inv1 = ~mq1;
    inv0 = ~mc;
    chk({tag, ".q1"},    q1,    mq1);
    chk({tag, ".nq1"},   nq1,   inv1);
    chk({tag, ".q0"},    q0,    mc);
    chk({tag, ".nq0"},   nq0,   inv0);
    chk({tag, ".sdo1"},  sdo1,  mc[7]);
    chk({tag, ".sdo0"},  sdo0,  mc[7]);
    chk({tag, ".busy1"}, busy1, 1'b0);
    chk({tag, ".busy0"}, busy0, 1'b0);
    chk({tag, ".done1"}, done1, 1'b0);
    chk({tag, ".done0"}, done0, 1'b0);
  endtask

  // One IDLE-cycle operation; the model applies Test > Update > Load.
  task automatic op(input bit ld, input bit tst, input bit upd,
                    input logic [7:0] d, input bit sdi, input string tag);
    Load = ld; Test = tst; Update = upd; D = d; SDI = sdi;
    tick();
    Load = 1'b0; Test = 1'b0; Update = 1'b0;
    if (tst) begin
      mc = {mc[6:0], sdi};
    end else if (upd) begin
      mq1 = mc;
    end else if (ld) begin
      mc  = d;
      mq1 = d;
    end
    check_idle(tag);
  endtask

  // Full auto-scan: bits[k] is the SDI value for the k-th shift edge.
  // With noise set, other controls are thrown at the DUT and must be ignored.
  task automatic autoscan(input logic [7:0] bits, input bit noise, input string tag);
    ScanStart = 1'b1;
    if (noise) begin
      Load = 1'b1; Test = 1'b1; D = ~mc;
    end
    tick();
    ScanStart = 1'b0; Load = 1'b0; Test = 1'b0;
    chk({tag, ".start.busy1"}, busy1, 1'b1);
    chk({tag, ".start.busy0"}, busy0, 1'b1);
    chk({tag, ".start.done1"}, done1, 1'b0);
    chk({tag, ".start.sdo1"},  sdo1,  mc[7]);
    chk({tag, ".start.q0"},    q0,    mc);
    chk({tag, ".start.q1"},    q1,    mq1);
    for (int k = 0; k < 8; k++) begin
      SDI = bits[k];
      if (noise) begin
        Load = 1'($urandom); Test = 1'($urandom); Update = 1'($urandom);
        ScanStart = 1'($urandom); D = 8'($urandom);
      end
      chk({tag, ".shift.sdo1"}, sdo1, mc[7]);
      chk({tag, ".shift.sdo0"}, sdo0, mc[7]);
      tick();
      mc = {mc[6:0], bits[k]};
      chk({tag, ".shift.busy1"}, busy1, 1'b1);
      chk({tag, ".shift.done1"}, done1, 1'b0);
      chk({tag, ".shift.q1"},    q1,    mq1);
      chk({tag, ".shift.q0"},    q0,    mc);
    end
    tick();
    Load = 1'b0; Test = 1'b0; Update = 1'b0; ScanStart = 1'b0;
    mq1 = mc;
    chk({tag, ".upd.done1"}, done1, 1'b1);
    chk({tag, ".upd.done0"}, done0, 1'b1);
    chk({tag, ".upd.busy1"}, busy1, 1'b0);
    chk({tag, ".upd.busy0"}, busy0, 1'b0);
    chk({tag, ".upd.q1"},    q1,    mq1);
    chk({tag, ".upd.q0"},    q0,    mc);
  endtask

  initial begin
    logic [7:0] r;
    total = 0; passed = 0; fails = 0;
    Reset = 1'b1; D = '0; Load = 1'b0; Test = 1'b0; SDI = 1'b0;
    Update = 1'b0; ScanStart = 1'b0;

    // Reset for two cycles.
    tick();
    tick();
    Reset = 1'b0;
    mc = RV; mq1 = RV;
    check_idle("reset");
    chk("reset.q_const",   q1,   8'hA5);
    chk("reset.nq_const",  nq1,  8'h5A);
    chk("reset.sdo_const", sdo1, 1'b1);

    // Parallel load.
    op(1, 0, 0, 8'h3C, 0, "load");
    chk("load.q_const",   q1,   8'h3C);
    chk("load.nq_const",  nq1,  8'hC3);
    chk("load.sdo_const", sdo1, 1'b0);

    // Auto-scan with SDI 1,0,1,1,0,0,1,0; SDO should read 0,0,1,1,1,1,0,0.
    autoscan(8'h4D, 0, "scan1");
    chk("scan1.q_const", q1, 8'hB2);
    tick();
    check_idle("scan1.after");

    // Manual shift of three ones from 3C, then Update.
    op(1, 0, 0, 8'h3C, 0, "man.load");
    op(0, 1, 0, 8'h00, 1, "man.s1");
    op(0, 1, 0, 8'h00, 1, "man.s2");
    op(0, 1, 0, 8'h00, 1, "man.s3");
    chk("man.q1_held",   q1, 8'h3C);
    chk("man.q0_ripple", q0, 8'hE7);
    op(0, 0, 1, 8'h00, 0, "man.update");
    chk("man.q1_upd", q1, 8'hE7);

    // IDLE priority corners.
    op(1, 0, 1, 8'h0F, 0, "prio.upd_over_load");
    op(1, 1, 1, 8'hF0, 0, "prio.test_over_all");

    // ScanStart beats Load/Test; controls asserted mid-scan are ignored.
    op(1, 0, 0, 8'h3C, 0, "noise.load");
    autoscan(8'($urandom), 1, "scan_noise");
    // Back-to-back: next scan accepted in the ScanDone cycle.
    autoscan(8'($urandom), 0, "scan_b2b");
    tick();
    check_idle("b2b.after");

    // Reset after the 4th shift aborts without update or ScanDone.
    ScanStart = 1'b1;
    tick();
    ScanStart = 1'b0;
    for (int k = 0; k < 4; k++) begin
      SDI = 1'($urandom);
      tick();
      mc = {mc[6:0], SDI};
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    mc = RV; mq1 = RV;
    check_idle("midreset");
    tick();
    check_idle("midreset.quiet");
    autoscan(8'($urandom), 0, "scan_after_reset");
    tick();
    check_idle("scan_after_reset.after");

    // Randomized mix of operations against the model.
    for (int i = 0; i < 40; i++) begin
      r = 8'($urandom);
      if (r[2:0] == 3'd0) begin
        autoscan(8'($urandom), r[3], "rnd.scan");
      end else begin
        op(r[4], r[5] & r[6], r[7], 8'($urandom), 1'($urandom), "rnd.op");
      end
    end
    tick();
    check_idle("final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
